// File: rtl/cbd_ibytes_tx.sv
// Lane-to-word bridge between the Keccak squeeze port and cbd: buffers lanes in a small FIFO,
// sends exactly 16 (eta=2) or 24 (eta=3) words and asks for one extra squeeze when needed.
module cbd_ibytes_tx #(
  parameter int unsigned W          = 64,
  parameter int unsigned RATE_LANES = 17,
  parameter int unsigned N_ETA2     = 16,
  parameter int unsigned N_ETA3     = 24,
  parameter int unsigned DEPTH      = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [1:0]   i_eta,
  input  logic [W-1:0] i_lane,
  input  logic         i_lane_valid,
  output logic         o_lane_ready,
  output logic         o_squeeze_req,
  output logic [W-1:0] o_ibytes,
  output logic         o_ibytes_valid,
  input  logic         i_ibytes_ready,
  output logic         o_busy,
  output logic         o_done
);

  localparam int unsigned CW = $clog2(N_ETA3 + 1);
  localparam int unsigned RW = $clog2(RATE_LANES);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q;
  logic [1:0]      eta_q;
  logic [CW-1:0]   in_cnt_q;
  logic [CW-1:0]   out_cnt_q;
  logic [RW-1:0]   rate_cnt_q;
  logic            squeeze_q;
  logic [W-1:0]    mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [OW-1:0]   occ_q;

  logic [CW-1:0]   n_c;
  logic            fifo_full_c;
  logic            fifo_empty_c;
  logic            lane_ready_c;
  logic            lane_hs_c;
  logic            out_hs_c;

  assign n_c          = (eta_q == 2'd3) ? CW'(N_ETA3) : CW'(N_ETA2);
  assign fifo_full_c  = (occ_q == OW'(DEPTH));
  assign fifo_empty_c = (occ_q == '0);
  assign lane_ready_c = (state_q == S_RUN) && !fifo_full_c && (in_cnt_q < n_c);
  assign lane_hs_c    = i_lane_valid && lane_ready_c;
  assign out_hs_c     = !fifo_empty_c && i_ibytes_ready;

  // Control: FSM, counters, squeeze pulse and FIFO pointers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      eta_q      <= 2'd0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      rate_cnt_q <= '0;
      squeeze_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
    end else begin
      squeeze_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start && (i_eta == 2'd2 || i_eta == 2'd3)) begin
            state_q    <= S_RUN;
            eta_q      <= i_eta;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            rate_cnt_q <= '0;
          end
        end
        S_RUN: begin
          if (lane_hs_c) begin
            in_cnt_q <= in_cnt_q + CW'(1);
            if (rate_cnt_q == RW'(RATE_LANES - 1)) begin
              rate_cnt_q <= '0;
              // another rate block is needed only if more lanes remain after this one
              squeeze_q  <= (in_cnt_q + CW'(1)) < n_c;
            end else begin
              rate_cnt_q <= rate_cnt_q + RW'(1);
            end
          end
          if (out_hs_c) begin
            out_cnt_q <= out_cnt_q + CW'(1);
            if (out_cnt_q == n_c - CW'(1)) state_q <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase

      if (lane_hs_c) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (out_hs_c)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({lane_hs_c, out_hs_c})
        2'b10:   occ_q <= occ_q + OW'(1);
        2'b01:   occ_q <= occ_q - OW'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while empty because the output is gated
  always_ff @(posedge i_clk) begin
    if (lane_hs_c) mem_q[wr_ptr_q] <= i_lane;
  end

  assign o_lane_ready   = lane_ready_c;
  assign o_squeeze_req  = squeeze_q;
  assign o_ibytes_valid = !fifo_empty_c;
  assign o_ibytes       = fifo_empty_c ? '0 : mem_q[rd_ptr_q];
  assign o_busy         = (state_q != S_IDLE);
  assign o_done         = (state_q == S_DONE);

endmodule
